// File: rtl/mem_dp_init_pkg.sv
// Shared definitions for the mem_dp_init dual-port RAM.
//   - memst_e         : clear-sequencer state encoding (MEMST_CLEAR / MEMST_READY)
//   - RL_MIN / RL_MAX : supported read-latency range
//   - mem_clog2()     : address width for a given depth, minimum 1 bit
//   - read_latency_ok(): legality test used by the elaboration-time check
package mem_dp_init_pkg;

  typedef enum logic {
    MEMST_CLEAR = 1'b0,
    MEMST_READY = 1'b1
  } memst_e;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  // A two-word memory still needs one address bit, hence the floor of 1.
  function automatic int mem_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit read_latency_ok(input int rl);
    return (rl >= RL_MIN) && (rl <= RL_MAX);
  endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Post-reset zero-clear sequencer for mem_dp_init.
// Walks the address counter from 0 to DEPTH-1, issuing one clear write per
// cycle, then parks in READY until the next reset.
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   busy_o     out  high while the clear is running
//   clr_we_o   out  clear write enable
//   clr_addr_o out  clear write address
module mem_init_seq
  import mem_dp_init_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter bit INIT  = 1'b0,
  parameter int AW    = mem_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam memst_e        RESET_ST  = INIT ? MEMST_CLEAR : MEMST_READY;

  memst_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_ST;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults assigned first so no path leaves a signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    case (state_q)
      MEMST_CLEAR: begin
        clr_we_o = 1'b1;
        // Stop on the last word instead of incrementing, so the counter never
        // points past DEPTH-1.
        if (cnt_q == LAST_ADDR) state_d = MEMST_READY;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      MEMST_READY: ;
    endcase
  end

  assign clr_addr_o = cnt_q;
  assign busy_o     = (state_q == MEMST_CLEAR);

endmodule

// File: rtl/mem_dp_init.sv
// Simple dual-port RAM (one write port, one read port, single clock) with
// optional post-reset zero clear, 1- or 2-cycle read latency, selectable
// same-address read-during-write behaviour and a q_valid strobe.
//   clock     in   clock, all logic on posedge
//   reset_n   in   asynchronous active-low reset
//   data      in   write data
//   wraddress in   write address
//   wren      in   write enable (ignored while busy)
//   rdaddress in   read address
//   rden      in   read enable (ignored while busy)
//   q         out  registered read data, holds between reads
//   q_valid   out  one-cycle strobe marking a new q
//   busy      out  high while the clear sequencer runs
module mem_dp_init
  import mem_dp_init_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 64,
  parameter int INIT         = 0,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1,
  localparam int AW          = mem_clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    wraddress,
  input  logic             wren,
  input  logic [AW-1:0]    rdaddress,
  input  logic             rden,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy
);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
    $error("mem_dp_init: READ_LATENCY must be 1 or 2");
  end

  // One extra bit so DEPTH itself is representable for the range compares.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  mem_init_seq #(
    .DEPTH (DEPTH),
    .INIT  (INIT != 0),
    .AW    (AW)
  ) u_init_seq (
    .clk        (clock),
    .rst_n      (reset_n),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // ---------------------------------------------------------------------------
  // Write port: clear sequencer owns it while busy, user otherwise.
  // ---------------------------------------------------------------------------
  logic             wr_in_range;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  assign wr_in_range = ({1'b0, wraddress} < DEPTH_W);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wraddress;
    mem_wdata = data;
    if (busy) begin
      mem_we    = clr_we;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else begin
      mem_we    = wren && wr_in_range;
    end
  end

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the storage array deliberately has no reset; clearing it is the
  // sequencer's job, and a reset here would stop RAM inference.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Read port: first stage resolves range and read-during-write.
  // ---------------------------------------------------------------------------
  logic             rd_fire;
  logic             rd_in_range;
  logic             same_addr;
  logic [WIDTH-1:0] rd_word;

  assign rd_fire     = rden && !busy;
  assign rd_in_range = ({1'b0, rdaddress} < DEPTH_W);
  assign same_addr   = wren && (wraddress == rdaddress);

  // The array read sees pre-edge contents, so read-first falls out naturally;
  // write-first forwards the incoming data on an address match.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if ((BYPASS != 0) && same_addr) rd_word = data;
      else                            rd_word = mem_q[rdaddress];
    end
  end

  logic [WIDTH-1:0] q_q;
  logic             q_valid_q;

  if (READ_LATENCY == 1) begin : g_rl1
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q_q       <= '0;
        q_valid_q <= 1'b0;
      end else begin
        q_valid_q <= rd_fire;
        if (rd_fire) q_q <= rd_word;
      end
    end
  end else begin : g_rl2
    logic [WIDTH-1:0] s1_data_q;
    logic             s1_valid_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s1_data_q  <= '0;
        s1_valid_q <= 1'b0;
        q_q        <= '0;
        q_valid_q  <= 1'b0;
      end else begin
        s1_valid_q <= rd_fire;
        if (rd_fire) s1_data_q <= rd_word;
        q_valid_q  <= s1_valid_q;
        if (s1_valid_q) q_q <= s1_data_q;
      end
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_mem_dp_init.sv
// Directed bench for mem_dp_init using two instances:
//   A: DEPTH=10, INIT=1, READ_LATENCY=1, BYPASS=1
//   B: DEPTH=64, INIT=1, READ_LATENCY=2, BYPASS=0
// Inputs are driven and outputs sampled on the falling edge.
module tb_mem_dp_init;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] data;
  logic [5:0] wraddress, rdaddress;
  logic       wren_a, rden_a, wren_b, rden_b;
  logic [7:0] q_a, q_b;
  logic       qv_a, qv_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_dp_init #(
    .WIDTH(8), .DEPTH(10), .INIT(1), .READ_LATENCY(1), .BYPASS(1)
  ) u_dut_a (
    .clock     (clk),
    .reset_n   (rst_a),
    .data      (data),
    .wraddress (wraddress[3:0]),
    .wren      (wren_a),
    .rdaddress (rdaddress[3:0]),
    .rden      (rden_a),
    .q         (q_a),
    .q_valid   (qv_a),
    .busy      (busy_a)
  );

  mem_dp_init #(
    .WIDTH(8), .DEPTH(64), .INIT(1), .READ_LATENCY(2), .BYPASS(0)
  ) u_dut_b (
    .clock     (clk),
    .reset_n   (rst_b),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren_b),
    .rdaddress (rdaddress),
    .rden      (rden_b),
    .q         (q_b),
    .q_valid   (qv_b),
    .busy      (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr_a(input logic [5:0] addr, input logic [7:0] d);
    wraddress = addr; data = d; wren_a = 1'b1;
    step();
    wren_a = 1'b0;
  endtask

  task automatic wr_b(input logic [5:0] addr, input logic [7:0] d);
    wraddress = addr; data = d; wren_b = 1'b1;
    step();
    wren_b = 1'b0;
  endtask

  // Latency-1 read on A: result is visible at the next falling edge.
  task automatic rd_a(input logic [5:0] addr, input logic [7:0] exp, input string tag);
    rdaddress = addr; rden_a = 1'b1;
    step();
    rden_a = 1'b0;
    check({tag, "_valid"}, qv_a, 1);
    check({tag, "_q"}, q_a, exp);
  endtask

  // Count cycles busy stays high after release; bounded.
  task automatic count_busy_a(output int n);
    n = 0;
    while (busy_a && n < 500) begin
      step();
      n++;
    end
  endtask

  logic [7:0] exp_a [10];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int bad_valid;
    rst_a = 1'b0; rst_b = 1'b0;
    data = '0; wraddress = '0; rdaddress = '0;
    wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_a_q", q_a, 0);
    check("rst_a_valid", qv_a, 0);
    check("rst_a_busy", busy_a, 1);
    check("rst_b_busy", busy_b, 1);

    // ---- Test 1: A clear lasts exactly DEPTH cycles, then all zero ----
    rst_a = 1'b1;
    count_busy_a(n);
    check("a_clear_len", n, 10);
    for (int i = 0; i < 10; i++) begin
      exp_a[i] = 8'h00;
      rd_a(6'(i), 8'h00, $sformatf("a_zero%0d", i));
    end
    step();
    check("a_sweep_end_valid", qv_a, 0);

    // ---- Test 2: write then read, latency 1, q holds ----
    wr_a(6'd3, 8'hA5); exp_a[3] = 8'hA5;
    check("a_pre_read_valid", qv_a, 0);
    rd_a(6'd3, 8'hA5, "a_rd3");
    step();
    check("a_hold_q", q_a, 8'hA5);
    check("a_hold_valid", qv_a, 0);

    // ---- Test 4 on A: BYPASS=1 returns the new data ----
    wr_a(6'd5, 8'h11);
    wraddress = 6'd5; data = 8'h22; wren_a = 1'b1;
    rd_a(6'd5, 8'h22, "a_bypass");
    wren_a = 1'b0; exp_a[5] = 8'h22;
    rd_a(6'd5, 8'h22, "a_after_bypass");
    // Different addresses in the same cycle are independent.
    wraddress = 6'd6; data = 8'h33; wren_a = 1'b1;
    rd_a(6'd5, 8'h22, "a_diff_addr");
    wren_a = 1'b0; exp_a[6] = 8'h33;

    // ---- Test 6: out-of-range write dropped, read returns 0 ----
    wr_a(6'd12, 8'hFF);
    rd_a(6'd3, 8'hA5, "a_pre_oor");
    rd_a(6'd12, 8'h00, "a_oor_read");
    for (int i = 0; i < 10; i++) rd_a(6'(i), exp_a[i], $sformatf("a_final%0d", i));

    // ---- B: clear length 64 ----
    rst_b = 1'b1;
    n = 0;
    while (busy_b && n < 500) begin step(); n++; end
    check("b_clear_len", n, 64);

    // ---- Test 3: latency-2 streaming of 0..7 ----
    for (int i = 0; i < 8; i++) wr_b(6'(i), 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      rdaddress = 6'(i); rden_b = (i < 8);
      step();
      if (i == 0) check("b_stream_lat", qv_b, 0);
      else if (i <= 8) begin
        check($sformatf("b_stream%0d_valid", i - 1), qv_b, 1);
        check($sformatf("b_stream%0d_q", i - 1), q_b, 8'h10 + (i - 1));
      end else begin
        check("b_stream_end_valid", qv_b, 0);
        check("b_stream_end_hold", q_b, 8'h17);
      end
    end
    rden_b = 1'b0;

    // ---- Test 4 on B: BYPASS=0 returns old data ----
    wr_b(6'd5, 8'h11);
    wraddress = 6'd5; data = 8'h22; wren_b = 1'b1;
    rdaddress = 6'd5; rden_b = 1'b1;
    step();
    wren_b = 1'b0; rden_b = 1'b0;
    check("b_rdw_lat", qv_b, 0);
    step();
    check("b_rdw_valid", qv_b, 1);
    check("b_rdw_q", q_b, 8'h11);
    rdaddress = 6'd5; rden_b = 1'b1;
    step(); rden_b = 1'b0;
    step();
    check("b_after_rdw_q", q_b, 8'h22);

    // ---- Test 5: reset with read in flight, reset mid-clear ----
    rdaddress = 6'd2; rden_b = 1'b1;
    step(); rden_b = 1'b0;
    rst_b = 1'b0;
    #1;
    check("b_inflight_q", q_b, 0);
    check("b_inflight_valid", qv_b, 0);
    check("b_inflight_busy", busy_b, 1);
    step(); step();
    check("b_inflight_discard", qv_b, 0);
    rst_b = 1'b1;
    repeat (20) step();
    check("b_mid_clear_busy", busy_b, 1);
    rst_b = 1'b0;
    #1;
    check("b_midclr_q", q_b, 0);
    check("b_midclr_valid", qv_b, 0);
    step();
    rst_b = 1'b1;
    n = 0; bad_valid = 0;
    data = 8'hEE;
    while (busy_b && n < 500) begin
      wren_b = 1'b1; rden_b = 1'b1;
      wraddress = 6'(n % 8); rdaddress = 6'(n % 8);
      if (qv_b) bad_valid++;
      step();
      n++;
    end
    wren_b = 1'b0; rden_b = 1'b0;
    check("b_reclear_len", n, 64);
    check("b_busy_valid_count", bad_valid, 0);
    check("b_busy_exit_valid", qv_b, 0);
    check("b_busy_q_hold", q_b, 0);
    for (int i = 0; i < 8; i++) begin
      rdaddress = 6'(i); rden_b = 1'b1;
      step(); rden_b = 1'b0;
      step();
      check($sformatf("b_zero%0d_valid", i), qv_b, 1);
      check($sformatf("b_zero%0d_q", i), q_b, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dp_init.md
Name: mem_dp_init

Overview:
Parametrised simple-dual-port RAM and the successor to the basic single-ported mem block. It has one write port and one read port on a single clock. Added over the basic block: a configurable read latency of 1 or 2, selectable read-during-write semantics, a q_valid strobe, and a hardware zero-clear sequencer that runs after reset. It is used for twiddle/coefficient and scratch buffers in the butterfly datapath.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 64, number of words (>=2; need not be a power of two).
- INIT, 0, 1 = zero every word with the clear sequencer after reset; 0 = contents undefined after reset.
- READ_LATENCY, 1, cycles from rden to q/q_valid; legal values 1 or 2.
- BYPASS, 1, same-address read-during-write: 1 = new data (write-first), 0 = old data (read-first).

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- data  in  WIDTH  write data.
- wraddress  in  AW  write address, where AW = CLOG2(DEPTH), minimum 1.
- wren  in  1  write enable.
- rdaddress  in  AW  read address.
- rden  in  1  read enable.
- q  out  WIDTH  read data, registered.
- q_valid  out  1  one-cycle strobe marking new q.
- busy  out  1  high while the clear sequencer runs.

Behaviour:
- Reset (async assert, sync release):
  - q=0, q_valid=0, read pipeline registers=0, clear counter=0.
  - state=CLEAR if INIT=1, else READY.
  - busy=1 iff state is CLEAR.
  - The storage array itself is not reset.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[cnt], then cnt++. After the cycle with cnt==DEPTH-1, go to READY.
  - READY: terminal until the next reset.
  - The clear therefore occupies exactly DEPTH cycles after reset release; busy deasserts on the edge that ends the last clear write.
- While busy:
  - wren and rden are ignored: no user write, q_valid stays 0, q holds.
  - Users must wait for busy=0 before issuing requests.
- Write (READY): wren=1 at edge N stores data at wraddress; the write is visible to reads issued at N+1.
- Read (READY): rden=1 at edge N samples rdaddress.
  - READ_LATENCY=1: q updates at edge N+1, q_valid=1 for that cycle.
  - READ_LATENCY=2: q updates at edge N+2, q_valid=1 for that cycle.
  - Back-to-back reads give one result per cycle, fully pipelined.
- rden=0: q holds its last value; q_valid=0.
- Same-address read and write in the same cycle: returned word is data (BYPASS=1) or the prior contents (BYPASS=0). Different addresses are independent.
- Out of range (address >= DEPTH, non-power-of-two DEPTH only): the write is dropped; the read returns 0 with q_valid=1.
- Reset mid-clear or mid-read:
  - In-flight reads are discarded (q_valid=0).
  - The clear restarts from address 0 if INIT=1.
- Arithmetic: cnt is AW bits and never wraps past DEPTH-1. Comparisons are unsigned.

Decomposition:
- Shared package/include:
  - CLOG2 macro (existing clog2.v).
  - State encodings MEMST_CLEAR and MEMST_READY.
  - Legal READ_LATENCY values, checked by an elaboration-time assertion.
- One sub-module, mem_init_seq:
  - Contains the CLEAR/READY FSM and address counter.
  - Outputs busy, clr_we and clr_addr; the top muxes these onto the write port.
- Top level holds the array, bypass compare and read pipeline.

Test Plan:
1. INIT=1, DEPTH=10: release reset. busy=1 for exactly 10 cycles. Then reading every address returns 0, each with q_valid pulsed.
2. READ_LATENCY=1: write 0xA5 at address 3. Next cycle, rden at address 3. q=0xA5 with q_valid=1 exactly one cycle later; q holds 0xA5 after rden drops.
3. READ_LATENCY=2: stream reads of addresses 0..7, preloaded with value=addr+0x10. q shows 0x10..0x17 on consecutive cycles starting 2 cycles after the first rden, with q_valid continuously high for 8 cycles.
4. Address 5 holds 0x11; same cycle wren data=0x22 and rden, both at address 5. BYPASS=1 gives q=0x22; BYPASS=0 gives q=0x11. A later read of address 5 returns 0x22 in both cases.
5. INIT=1, DEPTH=64: assert reset_n=0 at clear cycle 20 with a read in flight. q=0 and q_valid=0 immediately. After release the clear reruns the full 64 cycles. wren/rden pulsed during busy have no effect: q_valid=0 and memory stays zero.
6. DEPTH=10: write 0xFF at address 12, then read address 12. q=0 with q_valid=1, and addresses 0..9 are unchanged.
